// File: rtl/cocotb_array_streamer_if.sv
// ---------------------------------------------------------------------------
// cocotb_array_streamer_if
// Bundle of control and stream signals for cocotb_array_streamer.
//   start, abort       : control from the requester
//   in_arr             : source array [i][j][k], ENTRY_W bits per entry
//   out_valid/out_ready: element handshake
//   out_data           : current element
//   out_i/out_j/out_k  : current element indices (i outermost, k innermost)
//   out_last           : current element is the final one
//   busy, done         : streaming status / one-cycle completion pulse
// modport master: the streamer side. modport slave: the requester/consumer.
// ---------------------------------------------------------------------------
interface cocotb_array_streamer_if #(
    parameter int ENTRY_W = 3,
    parameter int DIM     = 3
);
    // Keep indices at least one bit wide so DIM=1 still elaborates.
    localparam int IDX_W = (DIM > 1) ? $clog2(DIM) : 1;

    logic               start;
    logic               abort;
    logic [ENTRY_W-1:0] in_arr [DIM-1:0][DIM-1:0][DIM-1:0];
    logic               out_valid;
    logic               out_ready;
    logic [ENTRY_W-1:0] out_data;
    logic [IDX_W-1:0]   out_i;
    logic [IDX_W-1:0]   out_j;
    logic [IDX_W-1:0]   out_k;
    logic               out_last;
    logic               busy;
    logic               done;

    modport master (
        input  start, abort, in_arr, out_ready,
        output out_valid, out_data, out_i, out_j, out_k, out_last, busy, done
    );

    modport slave (
        output start, abort, in_arr, out_ready,
        input  out_valid, out_data, out_i, out_j, out_k, out_last, busy, done
    );
endinterface

// File: rtl/cocotb_array_streamer.sv
// ---------------------------------------------------------------------------
// cocotb_array_streamer
// Snapshots a DIM x DIM x DIM array on start and streams it out one element
// per accepted transfer in i/j/k order (k innermost), flagging the final
// element with out_last and pulsing done for one cycle after it is taken.
// abort cancels a stream in progress without a done pulse.
// Ports:
//   clk : clock, rising edge
//   rst : asynchronous active-high reset
//   bus : cocotb_array_streamer_if.master (see interface header)
// ---------------------------------------------------------------------------
module cocotb_array_streamer #(
    parameter int ENTRY_W = 3,
    parameter int DIM     = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    cocotb_array_streamer_if.master  bus
);
    localparam int IW = (DIM > 1) ? $clog2(DIM) : 1;
    localparam logic [IW-1:0] MAX_IDX = IW'(DIM - 1);

    typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DONE} state_t;

    state_t             r_state;
    logic [ENTRY_W-1:0] r_snap [DIM-1:0][DIM-1:0][DIM-1:0];
    logic               r_valid;
    logic               r_last;
    logic               r_busy;
    logic               r_done;
    logic [ENTRY_W-1:0] r_data;
    logic [IW-1:0]      r_i, r_j, r_k;

    logic               w_xfer;
    logic               w_k_wrap, w_j_wrap;
    logic [IW-1:0]      w_ni, w_nj, w_nk;

    // Next element indices after a transfer. i never needs to wrap: the
    // transfer of (MAX,MAX,MAX) leaves STREAM instead of advancing.
    always_comb begin
        w_xfer   = r_valid && bus.out_ready;
        w_k_wrap = (r_k == MAX_IDX);
        w_j_wrap = (r_j == MAX_IDX);
        w_nk     = w_k_wrap ? '0 : r_k + 1'b1;
        w_nj     = r_j;
        w_ni     = r_i;
        if (w_k_wrap) begin
            w_nj = w_j_wrap ? '0 : r_j + 1'b1;
            if (w_j_wrap)
                w_ni = r_i + 1'b1;
        end
    end

    // Snapshot has no reset: it is only visible after the next capture.
    always_ff @(posedge clk) begin
        if (r_state == S_IDLE && bus.start)
            r_snap <= bus.in_arr;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_data  <= '0;
            r_i     <= '0;
            r_j     <= '0;
            r_k     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (bus.start) begin
                        r_state <= S_STREAM;
                        r_valid <= 1'b1;
                        r_busy  <= 1'b1;
                        r_i     <= '0;
                        r_j     <= '0;
                        r_k     <= '0;
                        // Snapshot is loading this same edge; take the
                        // first element straight from the input.
                        r_data  <= bus.in_arr[0][0][0];
                        r_last  <= (DIM == 1);
                    end
                end
                S_STREAM: begin
                    // abort takes priority over a coincident transfer.
                    if (bus.abort) begin
                        r_state <= S_IDLE;
                        r_valid <= 1'b0;
                        r_busy  <= 1'b0;
                        r_last  <= 1'b0;
                    end else if (w_xfer) begin
                        if (r_last) begin
                            r_state <= S_DONE;
                            r_valid <= 1'b0;
                            r_busy  <= 1'b0;
                            r_last  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_i    <= w_ni;
                            r_j    <= w_nj;
                            r_k    <= w_nk;
                            r_data <= r_snap[w_ni][w_nj][w_nk];
                            r_last <= (w_ni == MAX_IDX) && (w_nj == MAX_IDX) &&
                                      (w_nk == MAX_IDX);
                        end
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.out_valid = r_valid;
    assign bus.out_last  = r_last;
    assign bus.out_data  = r_data;
    assign bus.out_i     = r_i;
    assign bus.out_j     = r_j;
    assign bus.out_k     = r_k;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
endmodule

// File: tb/tb_cocotb_array_streamer.sv
module tb_cocotb_array_streamer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cocotb_array_streamer_if #(.ENTRY_W(3), .DIM(3)) bus ();

    cocotb_array_streamer #(.ENTRY_W(3), .DIM(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input bit sevens);
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                for (int k = 0; k < 3; k++)
                    bus.in_arr[i][j][k] = sevens ? 3'd7 : 3'((i + j + k) % 8);
    endtask

    task automatic start_pulse();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"}, 32'(bus.out_valid), 32'd0);
        chk({tag, "_last"},  32'(bus.out_last),  32'd0);
        chk({tag, "_busy"},  32'(bus.busy),      32'd0);
        chk({tag, "_done"},  32'(bus.done),      32'd0);
        chk({tag, "_data"},  32'(bus.out_data),  32'd0);
        chk({tag, "_idx"},   32'({bus.out_i, bus.out_j, bus.out_k}), 32'd0);
    endtask

    // Walks elements 0..n-1 of the (i+j+k)%8 array. pat=0: always ready;
    // pat=1: ready follows 1,0,0,1 repeating. Every cycle, stalled or not,
    // the shown element must equal the expected one, which also checks
    // stability during stalls.
    task automatic run_stream(input int pat, input int n);
        int cyc = 0;
        bit rdy;
        for (int e = 0; e < n; e++) begin
            int ei = e / 9;
            int ej = (e / 3) % 3;
            int ek = e % 3;
            do begin
                rdy = (pat == 0) || (cyc % 4 == 0) || (cyc % 4 == 3);
                bus.out_ready = rdy;
                chk("valid", 32'(bus.out_valid), 32'd1);
                chk("data",  32'(bus.out_data),  32'((ei + ej + ek) % 8));
                chk("idx",   32'({bus.out_i, bus.out_j, bus.out_k}), 32'(ei * 16 + ej * 4 + ek));
                chk("last",  32'(bus.out_last),  32'(e == 26));
                chk("busy",  32'(bus.busy),      32'd1);
                chk("done",  32'(bus.done),      32'd0);
                step();
                cyc++;
            end while (!rdy);
        end
        bus.out_ready = 1'b0;
    endtask

    task automatic chk_end(input string tag);
        chk({tag, "_end_valid"}, 32'(bus.out_valid), 32'd0);
        chk({tag, "_end_done"},  32'(bus.done),      32'd1);
        chk({tag, "_end_busy"},  32'(bus.busy),      32'd0);
        chk({tag, "_end_last"},  32'(bus.out_last),  32'd0);
        step();
        chk({tag, "_post_done"},  32'(bus.done),      32'd0);
        chk({tag, "_post_valid"}, 32'(bus.out_valid), 32'd0);
    endtask

    initial begin
        bus.start     = 1'b0;
        bus.abort     = 1'b0;
        bus.out_ready = 1'b0;
        fill(1'b0);

        // Reset state, before any clock edge.
        #2;
        chk_all_zero("reset");
        step();
        step();
        rst = 1'b0;
        step();
        chk_all_zero("idle");

        // Basic stream, always ready.
        start_pulse();
        run_stream(0, 27);
        chk_end("s1");

        // Back-pressure 1,0,0,1.
        start_pulse();
        run_stream(1, 27);
        chk_end("s2");

        // Input changed right after capture.
        start_pulse();
        fill(1'b1);
        run_stream(0, 27);
        chk_end("s3");
        fill(1'b0);

        // Abort after 5 transfers, coincident with out_ready=1.
        start_pulse();
        run_stream(0, 5);
        bus.abort     = 1'b1;
        bus.out_ready = 1'b1;
        step();
        bus.abort     = 1'b0;
        bus.out_ready = 1'b0;
        chk("abort_valid", 32'(bus.out_valid), 32'd0);
        chk("abort_busy",  32'(bus.busy),      32'd0);
        for (int c = 0; c < 3; c++) begin
            chk("abort_done",  32'(bus.done),      32'd0);
            chk("abort_quiet", 32'(bus.out_valid), 32'd0);
            step();
        end
        start_pulse();
        run_stream(0, 27);
        chk_end("s4");

        // Reset during the 10th element with out_ready=0.
        start_pulse();
        run_stream(0, 9);
        step();
        chk("stall_idx",  32'({bus.out_i, bus.out_j, bus.out_k}), 32'(1 * 16));
        chk("stall_data", 32'(bus.out_data), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk_all_zero("async_rst");
        step();
        rst = 1'b0;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step();
            chk("post_rst_valid", 32'(bus.out_valid), 32'd0);
            chk("post_rst_done",  32'(bus.done),      32'd0);
            chk("post_rst_busy",  32'(bus.busy),      32'd0);
        end
        bus.out_ready = 1'b0;
        start_pulse();
        run_stream(0, 27);
        chk_end("s5");

        // start held high through a whole stream, then one idle cycle.
        bus.start = 1'b1;
        step();
        run_stream(0, 27);
        chk_end("s6");
        step();
        bus.start = 1'b0;
        run_stream(0, 27);
        chk_end("s6b");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/cocotb_array_streamer.md
COCOTB_ARRAY_STREAMER -- requirements
Module: cocotb_array_streamer

Interface
REQ-001 The block SHALL take parameter ENTRY_W, default 3, as the width of one array entry in bits.
REQ-002 The block SHALL take parameter DIM, default 3, as the size of every array dimension.
REQ-003 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-004 Port clk, input, 1 bit: clock, all state on rising edge.
REQ-005 Port rst, input, 1 bit: asynchronous active-high reset.
REQ-006 Port start, input, 1 bit: capture in_arr and begin streaming.
REQ-007 Port abort, input, 1 bit: cancel the stream in progress.
REQ-008 Port in_arr, input, ENTRY_W per entry, unpacked [DIM-1:0][DIM-1:0][DIM-1:0]: source array.
REQ-009 Port out_valid, output, 1 bit: out_data and indices are valid.
REQ-010 Port out_ready, input, 1 bit: consumer accepts the element.
REQ-011 Port out_data, output, ENTRY_W bits: current element.
REQ-012 Port out_i, out_j, out_k, output, $clog2(DIM) bits each: indices of the current element, where i is outermost and k is innermost.
REQ-013 Port out_last, output, 1 bit: the current element is the final one.
REQ-014 Port busy, output, 1 bit: the block is in state STREAM.
REQ-015 Port done, output, 1 bit: one-cycle completion pulse.

Function
REQ-016 The FSM SHALL have three states: IDLE, STREAM and DONE.
REQ-017 In IDLE, start=1 SHALL capture all DIM^3 entries of in_arr into an internal snapshot, set i=j=k=0, and move to STREAM.
- Latency: out_valid rises on the cycle after start is sampled.
REQ-018 Changes on in_arr after capture SHALL NOT affect the streamed data.
REQ-019 In STREAM, out_valid SHALL be 1 and out_data SHALL equal snapshot[out_i][out_j][out_k].
REQ-020 A transfer SHALL occur only on a cycle where out_valid=1 and out_ready=1.
REQ-021 While out_valid=1 and out_ready=0, out_data, out_i, out_j, out_k and out_last SHALL hold stable.
REQ-022 On each transfer, the indices SHALL advance in this order:
- k increments;
- when k=DIM-1, k wraps to 0 and j increments;
- when j also =DIM-1, j wraps to 0 and i increments.
REQ-023 out_last SHALL be 1 exactly when i=j=k=DIM-1 and out_valid=1.
REQ-024 The transfer of the last element SHALL move the FSM to DONE; the next cycle SHALL have out_valid=0.
REQ-025 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-026 start SHALL be ignored in STREAM and in DONE.
REQ-027 start sampled in the cycle immediately after DONE (IDLE) SHALL begin a new stream normally.
REQ-028 abort=1 in STREAM SHALL return the FSM to IDLE on the next edge:
- out_valid=0 next cycle;
- no done pulse;
- abort wins over a simultaneous transfer, which still counts as accepted by the consumer.
REQ-029 abort SHALL be ignored in IDLE and in DONE.
REQ-030 For DIM=1, a stream SHALL consist of exactly one element with out_last=1.
REQ-031 Total transfers per completed stream SHALL be exactly DIM^3, with no duplicated and no skipped index.

Reset
REQ-032 While rst=1, independent of clk:
- the FSM SHALL be in IDLE;
- out_valid=0, out_last=0, busy=0, done=0;
- out_data=0, out_i=0, out_j=0, out_k=0.
REQ-033 Reset asserted mid-stream SHALL discard the stream with no done pulse; after release, the block SHALL wait for a new start.
REQ-034 The snapshot contents SHALL be don't-care after reset; they are never visible until the next capture.

Verification
REQ-035 Scenario: defaults, in_arr[i][j][k]=(i+j+k)%8, start pulse, out_ready held at 1.
- Response: 27 consecutive transfers, values 0,1,2,1,2,3,... ending with 6 and out_last=1 at (2,2,2).
- done=1 on the cycle after the last transfer.
REQ-036 Scenario: out_ready toggles 1,0,0,1 repeatedly.
- Response: outputs stay stable during stalls; the element sequence is identical to REQ-035.
REQ-037 Scenario: in_arr changed to all 7 one cycle after start.
- Response: the streamed values still match the pre-start array.
REQ-038 Scenario: abort asserted after the 5th transfer.
- Response: out_valid=0 next cycle, done never pulses, busy=0.
- A following start streams from (0,0,0).
REQ-039 Scenario: rst asserted during the 10th element with out_ready=0.
- Response: all outputs are 0 immediately, without waiting for a clock edge.
- After release, nothing happens until start.
REQ-040 Scenario: start held high continuously through a whole stream.
- Response: no restart mid-stream.
- A new stream begins on the cycle after DONE.
